// File: rtl/mem_bus_arbiter_pkg.sv
// Shared constants for the memory bus arbiter: transfer sizes, sequencer states
// and transfer-owner encoding.
package mem_bus_pkg;

  localparam logic [1:0] SZ_NONE = 2'b00;
  localparam logic [1:0] SZ_BYTE = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;
  localparam logic [1:0] SZ_WORD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DATA  = 2'd2
  } state_e;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  // Wide enough for the largest legal wait reload (WAIT_CYCLES-1 = 14).
  localparam int CNT_WIDTH = 4;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Requester and bus-side signals of the memory bus arbiter. The master modport is
// the arbiter's view (it masters the shared bus); slave is the environment's view.
interface mem_bus_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  i_req;
  logic [ADDR_WIDTH-1:0] i_addr;
  logic [1:0]            i_size;
  logic                  i_done;
  logic [DATA_WIDTH-1:0] i_rdata;

  logic                  d_req;
  logic                  d_rw;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [1:0]            d_size;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic                  d_done;
  logic [DATA_WIDTH-1:0] d_rdata;

  logic [ADDR_WIDTH-1:0] bus_addr;
  logic                  bus_rw;
  logic [1:0]            bus_size;
  logic [DATA_WIDTH-1:0] bus_wdata;
  logic [DATA_WIDTH-1:0] bus_rdata;

  logic                  busy;
  logic                  grant_d;

  modport master (
    input  i_req, i_addr, i_size,
    output i_done, i_rdata,
    input  d_req, d_rw, d_addr, d_size, d_wdata,
    output d_done, d_rdata,
    output bus_addr, bus_rw, bus_size, bus_wdata,
    input  bus_rdata,
    output busy, grant_d
  );

  modport slave (
    output i_req, i_addr, i_size,
    input  i_done, i_rdata,
    output d_req, d_rw, d_addr, d_size, d_wdata,
    input  d_done, d_rdata,
    input  bus_addr, bus_rw, bus_size, bus_wdata,
    output bus_rdata,
    input  busy, grant_d
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational grant selection between fetch (I) and load/store (D).
// MEM_ARB_RR_EN selects round-robin on contention; otherwise D has fixed priority.
module mem_arb_pick
  import mem_bus_pkg::*;
(
  input  logic i_req,
  input  logic d_req,
`ifdef MEM_ARB_RR_EN
  input  logic last_owner,
`endif
  output logic req_any,
  output logic grant_d
);

  assign req_any = i_req | d_req;

`ifdef MEM_ARB_RR_EN
  // On contention the port that did not own the previous transfer wins.
  assign grant_d = (i_req && d_req) ? (last_owner == OWN_I) : d_req;
`else
  assign grant_d = d_req;
`endif

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the single CPU memory bus between fetch and load/store, one transfer at a
// time (IDLE -> ISSUE -> DATA). Optional round-robin arbitration: MEM_ARB_RR_EN.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst,
  mem_bus_arbiter_if.master   mb
);

  localparam logic [CNT_WIDTH-1:0] WAIT_LOAD = CNT_WIDTH'(WAIT_CYCLES - 1);

  state_e                 r_state;
  state_e                 w_next_state;
  logic                   r_owner;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic                   r_rw;
  logic [1:0]             r_size;
  logic [DATA_WIDTH-1:0]  r_wdata;
  logic [CNT_WIDTH-1:0]   r_cnt;

  logic                   w_req_any;
  logic                   w_pick_d;
  logic                   w_start;
  logic                   w_done;
  logic                   w_busy;

`ifdef MEM_ARB_RR_EN
  logic                   r_last_owner;

  mem_arb_pick u_pick (
    .i_req      (mb.i_req),
    .d_req      (mb.d_req),
    .last_owner (r_last_owner),
    .req_any    (w_req_any),
    .grant_d    (w_pick_d)
  );
`else
  mem_arb_pick u_pick (
    .i_req      (mb.i_req),
    .d_req      (mb.d_req),
    .req_any    (w_req_any),
    .grant_d    (w_pick_d)
  );
`endif

  // NOTE: every signal written here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b0;
    w_done       = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_req_any) begin
          w_start      = 1'b1;
          w_next_state = ST_ISSUE;
        end
      end
      ST_ISSUE: w_next_state = ST_DATA;
      ST_DATA: begin
        if (r_cnt == '0) begin
          w_done       = 1'b1;
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register sees
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_owner <= OWN_I;
      r_addr  <= '0;
      r_rw    <= 1'b0;
      r_size  <= SZ_NONE;
      r_wdata <= '0;
      r_cnt   <= '0;
`ifdef MEM_ARB_RR_EN
      r_last_owner <= OWN_I;
`endif
    end else begin
      r_state <= w_next_state;
      if (w_start) begin
        r_owner <= w_pick_d;
        if (w_pick_d) begin
          r_addr  <= mb.d_addr;
          r_rw    <= mb.d_rw;
          r_size  <= mb.d_size;
          r_wdata <= mb.d_wdata;
        end else begin
          // Fetch is read-only: direction and write data are forced clean.
          r_addr  <= mb.i_addr;
          r_rw    <= 1'b0;
          r_size  <= mb.i_size;
          r_wdata <= '0;
        end
`ifdef MEM_ARB_RR_EN
        r_last_owner <= w_pick_d;
`endif
      end
      if (r_state == ST_ISSUE) begin
        r_cnt <= WAIT_LOAD;
      end else if (r_state == ST_DATA && r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  assign w_busy       = (r_state != ST_IDLE);

  // Slaves only see an access while a transfer is in flight.
  assign mb.bus_addr  = r_addr;
  assign mb.bus_wdata = r_wdata;
  assign mb.bus_size  = w_busy ? r_size : SZ_NONE;
  assign mb.bus_rw    = w_busy & r_rw;

  assign mb.busy      = w_busy;
  assign mb.grant_d   = r_owner;
  assign mb.i_done    = w_done & (r_owner == OWN_I);
  assign mb.d_done    = w_done & (r_owner == OWN_D);
  assign mb.i_rdata   = mb.bus_rdata;
  assign mb.d_rdata   = mb.bus_rdata;

endmodule
